// File: rtl/dmem_router.sv
// Data-side router: decodes core requests into scratch-pad banks or external memory,
// keeps one transaction in flight and adds error/timeout responses and access counters.
module dmem_router #(
    parameter int unsigned       DWidth        = 32,
    parameter int unsigned       NumBanks      = 4,
    parameter logic [DWidth-1:0] SpadBase      = 32'h8000_0000,
    parameter int unsigned       SpadSizeLog2  = 12,
    parameter int unsigned       TimeoutCycles = 16,
    parameter int unsigned       CntWidth      = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         core_req_i,
    input  logic                         core_write_i,
    input  logic [DWidth-1:0]            core_addr_i,
    input  logic [DWidth-1:0]            core_wdata_i,
    output logic                         core_ready_o,
    output logic [DWidth-1:0]            core_rdata_o,
    output logic                         core_err_o,
    output logic [NumBanks-1:0]          spad_req_o,
    output logic                         spad_write_o,
    output logic [DWidth-1:0]            spad_addr_o,
    output logic [DWidth-1:0]            spad_wdata_o,
    input  logic [NumBanks-1:0]          spad_ready_i,
    input  logic [NumBanks*DWidth-1:0]   spad_rdata_i,
    output logic                         dmem_req_o,
    output logic                         dmem_write_o,
    output logic [DWidth-1:0]            dmem_addr_o,
    output logic [DWidth-1:0]            dmem_wdata_o,
    input  logic                         dmem_ready_i,
    input  logic [DWidth-1:0]            dmem_rdata_i,
    output logic [CntWidth-1:0]          spad_cnt_o,
    output logic [CntWidth-1:0]          dmem_cnt_o,
    output logic [CntWidth-1:0]          err_cnt_o
);

    localparam int unsigned       BankSelW = (NumBanks > 1) ? $clog2(NumBanks) : 1;
    localparam int unsigned       TmoW     = $clog2(TimeoutCycles);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TimeoutCycles - 1);
    localparam logic [DWidth-1:0] ErrData  = DWidth'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {IDLE, BUSY, ERR, RESP} state_t;

    state_t                state_q, state_d;
    logic                  sel_spad_q;
    logic                  sel_write_q;
    logic [BankSelW-1:0]   sel_bank_q;
    logic [TmoW-1:0]       tmo_q;

    logic                  spad_hit;
    logic                  misaligned;
    logic [BankSelW-1:0]   bank;
    logic                  tgt_ready;
    logic [DWidth-1:0]     tgt_rdata;
    logic                  accept;
    logic                  raise_err;
    logic                  done_ok;
    logic                  tmo_fire;

    assign spad_hit   = core_addr_i[DWidth-1:SpadSizeLog2] == SpadBase[DWidth-1:SpadSizeLog2];
    assign misaligned = core_addr_i[1:0] != 2'b00;

    generate
        if (NumBanks > 1) begin : g_multi_bank
            assign bank = core_addr_i[2 +: BankSelW];
        end else begin : g_single_bank
            assign bank = '0;
        end
    endgenerate

    // Only the latched target may complete the transaction; everything else is ignored.
    assign tgt_ready = sel_spad_q ? spad_ready_i[sel_bank_q] : dmem_ready_i;
    assign tgt_rdata = sel_spad_q ? spad_rdata_i[int'(sel_bank_q)*DWidth +: DWidth] : dmem_rdata_i;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        raise_err = 1'b0;
        done_ok   = 1'b0;
        tmo_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (misaligned) begin
                        raise_err = 1'b1;
                        state_d   = ERR;
                    end else begin
                        accept  = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (tgt_ready) begin
                    done_ok = 1'b1;
                    state_d = RESP;
                end else if (tmo_q == TmoLast) begin
                    tmo_fire = 1'b1;
                    state_d  = RESP;
                end
            end
            ERR:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            sel_spad_q   <= 1'b0;
            sel_write_q  <= 1'b0;
            sel_bank_q   <= '0;
            tmo_q        <= '0;
            core_ready_o <= 1'b0;
            core_rdata_o <= '0;
            core_err_o   <= 1'b0;
            spad_req_o   <= '0;
            spad_write_o <= 1'b0;
            spad_addr_o  <= '0;
            spad_wdata_o <= '0;
            dmem_req_o   <= 1'b0;
            dmem_write_o <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            spad_cnt_o   <= '0;
            dmem_cnt_o   <= '0;
            err_cnt_o    <= '0;
        end else begin
            state_q      <= state_d;
            core_ready_o <= 1'b0;
            core_rdata_o <= '0;
            core_err_o   <= 1'b0;

            if (accept) begin
                sel_spad_q  <= spad_hit;
                sel_write_q <= core_write_i;
                sel_bank_q  <= bank;
                tmo_q       <= '0;
                if (spad_hit) begin
                    spad_req_o   <= NumBanks'(1) << bank;
                    spad_write_o <= core_write_i;
                    spad_addr_o  <= core_addr_i;
                    spad_wdata_o <= core_wdata_i;
                end else begin
                    dmem_req_o   <= 1'b1;
                    dmem_write_o <= core_write_i;
                    dmem_addr_o  <= core_addr_i;
                    dmem_wdata_o <= core_wdata_i;
                end
            end

            if (state_q == BUSY && !done_ok && !tmo_fire) begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (done_ok || tmo_fire) begin
                spad_req_o   <= '0;
                dmem_req_o   <= 1'b0;
                core_ready_o <= 1'b1;
            end

            if (done_ok) begin
                core_rdata_o <= sel_write_q ? '0 : tgt_rdata;
                if (sel_spad_q) begin
                    spad_cnt_o <= sat_inc(spad_cnt_o);
                end else begin
                    dmem_cnt_o <= sat_inc(dmem_cnt_o);
                end
            end

            if (tmo_fire || raise_err) begin
                core_ready_o <= 1'b1;
                core_err_o   <= 1'b1;
                core_rdata_o <= ErrData;
                err_cnt_o    <= sat_inc(err_cnt_o);
            end
        end
    end

endmodule

// File: tb/tb_dmem_router.sv
// Directed bench for dmem_router: table of single transactions plus timeout and
// mid-transaction reset sequences.
module tb_dmem_router;

    logic         clk = 1'b0;
    logic         rst;
    logic         core_req;
    logic         core_write;
    logic [31:0]  core_addr;
    logic [31:0]  core_wdata;
    logic         core_ready;
    logic [31:0]  core_rdata;
    logic         core_err;
    logic [3:0]   spad_req;
    logic         spad_write;
    logic [31:0]  spad_addr;
    logic [31:0]  spad_wdata;
    logic [3:0]   spad_ready;
    logic [127:0] spad_rdata;
    logic         dmem_req;
    logic         dmem_write;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic         dmem_ready;
    logic [31:0]  dmem_rdata;
    logic [15:0]  spad_cnt;
    logic [15:0]  dmem_cnt;
    logic [15:0]  err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_spad = 0;
    int exp_dmem = 0;
    int exp_errc = 0;

    always #5 clk = ~clk;

    dmem_router #(
        .DWidth(32),
        .NumBanks(4),
        .SpadBase(32'h8000_0000),
        .SpadSizeLog2(12),
        .TimeoutCycles(16),
        .CntWidth(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .core_req_i(core_req),
        .core_write_i(core_write),
        .core_addr_i(core_addr),
        .core_wdata_i(core_wdata),
        .core_ready_o(core_ready),
        .core_rdata_o(core_rdata),
        .core_err_o(core_err),
        .spad_req_o(spad_req),
        .spad_write_o(spad_write),
        .spad_addr_o(spad_addr),
        .spad_wdata_o(spad_wdata),
        .spad_ready_i(spad_ready),
        .spad_rdata_i(spad_rdata),
        .dmem_req_o(dmem_req),
        .dmem_write_o(dmem_write),
        .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata),
        .dmem_ready_i(dmem_ready),
        .dmem_rdata_i(dmem_rdata),
        .spad_cnt_o(spad_cnt),
        .dmem_cnt_o(dmem_cnt),
        .err_cnt_o(err_cnt)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned delay;
        logic [31:0] rdata;
        logic [3:0]  exp_sreq;
        logic        exp_dmem;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_counters();
        check("spad_cnt", 32'(spad_cnt), 32'(exp_spad));
        check("dmem_cnt", 32'(dmem_cnt), 32'(exp_dmem));
        check("err_cnt", 32'(err_cnt), 32'(exp_errc));
    endtask

    task automatic run_txn(input vec_t v);
        int sel = 0;
        for (int b = 0; b < 4; b++) if (v.exp_sreq[b]) sel = b;
        @(negedge clk);
        core_req   = 1'b1;
        core_write = v.write;
        core_addr  = v.addr;
        core_wdata = v.wdata;
        @(negedge clk);
        if (v.exp_err) begin
            check("err_ready", 32'(core_ready), 32'd1);
            check("err_flag", 32'(core_err), 32'd1);
            check("err_rdata", core_rdata, v.exp_rdata);
            check("err_no_spad_req", 32'(spad_req), 32'd0);
            check("err_no_dmem_req", 32'(dmem_req), 32'd0);
            core_req = 1'b0;
            exp_errc++;
            check_counters();
            @(negedge clk);
            check("err_ready_drop", 32'(core_ready), 32'd0);
        end else begin
            check("spad_req", 32'(spad_req), 32'(v.exp_sreq));
            check("dmem_req", 32'(dmem_req), 32'(v.exp_dmem));
            check("early_ready", 32'(core_ready), 32'd0);
            if (v.exp_dmem) begin
                check("dmem_addr", dmem_addr, v.addr);
                check("dmem_write", 32'(dmem_write), 32'(v.write));
                if (v.write) check("dmem_wdata", dmem_wdata, v.wdata);
            end else begin
                check("spad_addr", spad_addr, v.addr);
                check("spad_write", 32'(spad_write), 32'(v.write));
                if (v.write) check("spad_wdata", spad_wdata, v.wdata);
            end
            for (int d = 0; d < int'(v.delay); d++) begin
                // readies from every non-selected target must be ignored
                spad_ready = ~v.exp_sreq;
                dmem_ready = ~v.exp_dmem;
                @(negedge clk);
                check("req_held_spad", 32'(spad_req), 32'(v.exp_sreq));
                check("req_held_dmem", 32'(dmem_req), 32'(v.exp_dmem));
                check("no_ready_wait", 32'(core_ready), 32'd0);
            end
            for (int b = 0; b < 4; b++)
                spad_rdata[b*32 +: 32] = (v.exp_sreq != 4'd0 && b == sel) ? v.rdata : 32'hF0F0_0000 + 32'(b);
            dmem_rdata = v.exp_dmem ? v.rdata : 32'hBADB_AD00;
            spad_ready = v.exp_sreq;
            dmem_ready = v.exp_dmem;
            @(negedge clk);
            spad_ready = '0;
            dmem_ready = 1'b0;
            core_req   = 1'b0;
            check("resp_ready", 32'(core_ready), 32'd1);
            check("resp_err", 32'(core_err), 32'd0);
            check("resp_rdata", core_rdata, v.exp_rdata);
            check("resp_spad_drop", 32'(spad_req), 32'd0);
            check("resp_dmem_drop", 32'(dmem_req), 32'd0);
            if (v.exp_dmem) exp_dmem++;
            else exp_spad++;
            check_counters();
            @(negedge clk);
            check("bubble_ready", 32'(core_ready), 32'd0);
            check("bubble_rdata", core_rdata, 32'd0);
        end
    endtask

    initial begin
        int hi;
        logic got;
        vec_t post;

        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,         2, 32'h1234_5678, 4'b0000, 1'b1, 1'b0, 32'h1234_5678};
        vecs[1]  = '{1'b1, 32'h8000_0000, 32'h1111_1111, 0, 32'hCAFE_0001, 4'b0001, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h8000_0004, 32'h2222_2222, 0, 32'hCAFE_0002, 4'b0010, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h8000_0008, 32'h3333_3333, 0, 32'hCAFE_0003, 4'b0100, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h8000_000C, 32'h4444_4444, 0, 32'hCAFE_0004, 4'b1000, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h8000_1000, 32'h0,         1, 32'hA5A5_0001, 4'b0000, 1'b1, 1'b0, 32'hA5A5_0001};
        vecs[6]  = '{1'b0, 32'h0000_0102, 32'h0,         0, 32'h0,         4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, 32'h8000_0FFC, 32'h0,         0, 32'h0BAD_F00D, 4'b1000, 1'b0, 1'b0, 32'h0BAD_F00D};
        vecs[8]  = '{1'b0, 32'h8000_0014, 32'h0,         3, 32'h5555_AAAA, 4'b0010, 1'b0, 1'b0, 32'h5555_AAAA};
        vecs[9]  = '{1'b1, 32'h0000_0200, 32'h7777_8888, 1, 32'hCAFE_0009, 4'b0000, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h8000_0001, 32'h9999_0000, 0, 32'h0,         4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         0, 32'h3C3C_C3C3, 4'b0000, 1'b1, 1'b0, 32'h3C3C_C3C3};
        post     = '{1'b0, 32'h8000_0008, 32'h0,         0, 32'h6789_ABCD, 4'b0100, 1'b0, 1'b0, 32'h6789_ABCD};

        rst        = 1'b1;
        core_req   = 1'b0;
        core_write = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        spad_ready = '0;
        spad_rdata = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_core_ready", 32'(core_ready), 32'd0);
        check("rst_core_rdata", core_rdata, 32'd0);
        check("rst_spad_req", 32'(spad_req), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check_counters();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_txn(vecs[i]);

        // Target that never answers: request held for exactly TimeoutCycles.
        @(negedge clk);
        core_req   = 1'b1;
        core_write = 1'b0;
        core_addr  = 32'h0000_0300;
        hi  = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (core_ready) begin
                got = 1'b1;
                break;
            end
            if (dmem_req) hi++;
        end
        core_req = 1'b0;
        check("tmo_response", 32'(got), 32'd1);
        check("tmo_req_cycles", 32'(hi), 32'd16);
        check("tmo_err", 32'(core_err), 32'd1);
        check("tmo_rdata", core_rdata, 32'hDEAD_BEEF);
        check("tmo_req_drop", 32'(dmem_req), 32'd0);
        exp_errc++;
        check_counters();
        repeat (4) @(negedge clk);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        dmem_ready = 1'b0;
        check("late_ready_ignored", 32'(core_ready), 32'd0);
        @(negedge clk);
        check("late_ready_ignored2", 32'(core_ready), 32'd0);
        check_counters();

        // Reset while a bank request is outstanding.
        core_req   = 1'b1;
        core_write = 1'b0;
        core_addr  = 32'h8000_0004;
        @(negedge clk);
        check("pre_rst_spad_req", 32'(spad_req), 32'b0010);
        rst = 1'b1;
        @(negedge clk);
        exp_spad = 0;
        exp_dmem = 0;
        exp_errc = 0;
        check("mid_rst_spad_req", 32'(spad_req), 32'd0);
        check("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
        check("mid_rst_ready", 32'(core_ready), 32'd0);
        check("mid_rst_spad_addr", spad_addr, 32'd0);
        check("mid_rst_dmem_addr", dmem_addr, 32'd0);
        check_counters();
        rst        = 1'b0;
        core_req   = 1'b0;
        spad_ready = 4'b0010;
        @(negedge clk);
        spad_ready = '0;
        check("post_rst_ready_ignored", 32'(core_ready), 32'd0);
        check("post_rst_no_req", 32'(spad_req), 32'd0);
        @(negedge clk);
        check("post_rst_ready_ignored2", 32'(core_ready), 32'd0);
        run_txn(post);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_router.md
Name: dmem_router

Overview:
Parametrised data-side router between the scalar core's single data port and NumBanks scratch-pad banks plus the external data memory.
- Decodes each core request by address window and word-interleaves scratch-pad traffic across banks.
- Holds one transaction in flight and returns the selected target's response to the core.
- Adds misalignment/timeout error responses and per-target access counters.
- Sits inside the CPU top between the core and the scratch-pad/data-memory interfaces.

Parameters:
DWidth, 32, data/address width.
NumBanks, 4, scratch-pad bank count; power of two, 1..8.
SpadBase, 32'h8000_0000, scratch-pad window base; aligned to 2**SpadSizeLog2.
SpadSizeLog2, 12, log2 of scratch-pad window size in bytes (all banks together).
TimeoutCycles, 16, max cycles a target may take before an error response; >=2.
CntWidth, 16, width of statistics counters.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
core_req_i  in  1  core request; held until core_ready_o
core_write_i  in  1  1=store, 0=load
core_addr_i  in  DWidth  byte address
core_wdata_i  in  DWidth  store data
core_ready_o  out  1  one-cycle response pulse
core_rdata_o  out  DWidth  load data, valid with core_ready_o
core_err_o  out  1  error pulse, coincident with core_ready_o
spad_req_o  out  NumBanks  one-hot bank request
spad_write_o  out  1  shared bank write enable
spad_addr_o  out  DWidth  shared bank address
spad_wdata_o  out  DWidth  shared bank write data
spad_ready_i  in  NumBanks  per-bank ready pulse
spad_rdata_i  in  NumBanks*DWidth  per-bank read data, bank b at [b*DWidth +: DWidth]
dmem_req_o  out  1  external memory request
dmem_write_o  out  1  external write enable
dmem_addr_o  out  DWidth  external address
dmem_wdata_o  out  DWidth  external write data
dmem_ready_i  in  1  external ready pulse
dmem_rdata_i  in  DWidth  external read data
spad_cnt_o  out  CntWidth  completed scratch-pad accesses
dmem_cnt_o  out  CntWidth  completed external accesses
err_cnt_o  out  CntWidth  error responses

Behaviour:
- Reset: every output is 0, FSM=IDLE, counters=0. Reset mid-transaction drops all requests at the next edge; the pending response is lost and no late ready is forwarded.
- Decode:
  - spad_hit = core_addr_i[DWidth-1:SpadSizeLog2] == SpadBase[DWidth-1:SpadSizeLog2].
  - bank = core_addr_i[2 +: log2(NumBanks)].
  - misaligned = core_addr_i[1:0] != 0.
- FSM IDLE:
  - Samples core_req_i. If 1 and misaligned, go to ERR.
  - Otherwise, register addr/wdata/write onto the chosen target's bus and assert its req at the next cycle. The target is spad_req_o[bank] if spad_hit, else dmem_req_o. Then go to BUSY and clear the timeout counter.
- FSM BUSY:
  - Target req stays high.
  - Selected target's ready=1: drop req next cycle; core_ready_o=1 next cycle; core_rdata_o = target rdata for loads, 0 for stores. Increment spad_cnt_o or dmem_cnt_o; go to RESP.
  - Timeout counter reaches TimeoutCycles-1 with no ready: drop req; core_ready_o=1, core_err_o=1, core_rdata_o=32'hDEAD_BEEF; increment err_cnt_o; go to RESP.
  - A ready that arrives on the same cycle as the timeout wins (normal response).
- FSM ERR: one cycle. Outputs core_ready_o=1, core_err_o=1, core_rdata_o=32'hDEAD_BEEF; increments err_cnt_o; go to RESP. No downstream request is issued.
- FSM RESP: one bubble cycle. core_ready_o returns to 0 and core_req_i is ignored (the core deasserts or presents a new request); go to IDLE.
- Latency: request sampled at T → target req high at T+1 → target ready at R → core_ready_o at R+1 → next request accepted at R+2 at the earliest. Minimum round trip (ready at T+1) is 3 cycles request-to-accept.
- Ready from a non-selected target, or any ready in IDLE/RESP/ERR, is ignored.
- core_rdata_o/core_err_o are 0 whenever core_ready_o=0.
- Target address/wdata/write buses hold their last values while req=0. Unselected spad_req_o bits are always 0.
- Counters saturate at all-ones.

Test Plan:
- Load addr 32'h0000_0100, dmem_ready_i 3 cycles after dmem_req_o rises with rdata 32'h1234_5678 → core_ready_o one cycle later with rdata 32'h1234_5678, err 0; dmem_cnt_o=1; no spad_req_o bit set.
- Stores to 32'h8000_0000, _0004, _0008, _000C with NumBanks=4, each bank ready after 1 cycle → spad_req_o = 0001, 0010, 0100, 1000 in turn; spad_cnt_o=4; core_rdata_o=0.
- Load 32'h8000_1000 (just past the window) → routed to dmem_req_o, not to the scratch pad.
- Load 32'h0000_0102 → ERR path: core_ready_o+core_err_o one cycle after sampling, rdata 32'hDEAD_BEEF, no downstream req, err_cnt_o=1.
- dmem never ready, TimeoutCycles=16 → dmem_req_o high exactly 16 cycles, then error response. A late dmem_ready_i 5 cycles later produces no core_ready_o.
- rst_i asserted while in BUSY with spad_req_o=0010 → all outputs and counters 0 next cycle. A bank ready in the following cycle is ignored, and a new request after reset completes normally.
